multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1, number of EXEC cycles (1..15).
REQ-002 Parameter MEM_TIMEOUT, default 8, maximum MEM-state cycles without memAck before abort (1..255).
REQ-003 Parameter CMOV_SETTLE, default 1, extra flag-settle cycles for CMOV after EXEC (0..7).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 opcode  input  6  instruction opcode, sampled in DECODE.
REQ-007 func  input  5  R-type function field, sampled in DECODE.
REQ-008 INT  input  1  interrupt/resume request, level-sampled in HALT.
REQ-009 memAck  input  1  data memory completion, sampled in MEM.
REQ-010 aluOp  output  4  ALU operation select.
REQ-011 brOp  output  3  branch condition: 000 BR, 001 BMI, 010 BPL, 011 BZ, 100 none.
REQ-012 aluSrc, regAluOut, immSel, isCmov, mToReg  output  1 each  datapath selects.
REQ-013 rdMem, wrMem, wrReg, updPC  output  1 each  strobes.
REQ-014 halted  output  1  high while in HALT state.
REQ-015 illegal  output  1  one-cycle pulse on undefined opcode.
REQ-016 memErr  output  1  one-cycle pulse on memory timeout.

Function
REQ-017 States SHALL be FETCH, DECODE, EXEC, CSETTLE, MEM, WB, UPD, HALT; all outputs registered.
REQ-018 FETCH: all strobes 0; next DECODE.
REQ-019 DECODE: latch opcode/func internally; drive selects per REQ-020..REQ-023; load counter; undefined opcode -> illegal=1, next UPD; HALT (0x24) -> HALT; else -> EXEC.
REQ-020 aluOp: R-type (0x00) func[3:0]-1 mod 16; I-type 0x01..0x0F opcode[3:0]-1; LUI (0x10) 4'hF; all others 0000.
REQ-021 aluSrc=1 and regAluOut=1 for R-type, MOVE (0x14), CMOV (0x15); else 0.
REQ-022 immSel=1 for BR/BMI/BPL/BZ (0x20..0x23); else 0; isCmov=1 only for CMOV, held through WB.
REQ-023 Defined opcodes: 0x00..0x12, 0x14, 0x15, 0x20..0x26; everything else undefined.
REQ-024 EXEC: remain exactly ALU_LAT cycles; then LD (0x11)/ST (0x12) -> MEM; CMOV -> CSETTLE (skip to WB if CMOV_SETTLE=0); branches, NOP (0x25) -> UPD; all others -> WB.
REQ-025 CSETTLE: remain exactly CMOV_SETTLE cycles, then WB.
REQ-026 MEM: rdMem (LD) or wrMem (ST) high every MEM cycle; on memAck=1: LD -> WB with mToReg=1, ST -> UPD; strobe drops the cycle after ack sampled.
REQ-027 MEM timeout: MEM_TIMEOUT cycles without ack -> memErr=1 one cycle, strobes 0, next UPD, no register write.
REQ-028 memAck outside MEM SHALL be ignored.
REQ-029 WB: wrReg=1 exactly one cycle; next UPD; mToReg, isCmov cleared on exit.
REQ-030 UPD: updPC=1 exactly one cycle; next FETCH; all other strobes 0.
REQ-031 HALT: halted=1, strobes 0; remain until INT=1 sampled, then UPD.
REQ-032 INT outside HALT SHALL have no effect.
REQ-033 Instruction latency (DECODE to UPD inclusive) for R-type with ALU_LAT=1: 4 cycles (DECODE, EXEC, WB, UPD).

Reset
REQ-034 rst=1 at clock edge forces FETCH, counters 0, every output 0, aluOp=0000, brOp=100, regardless of current state (including mid-MEM or HALT).
REQ-035 rst has priority over memAck and INT in the same cycle; first post-reset cycle is FETCH.

Verification
REQ-036 R-type opcode 0x00 func 0x03, defaults -> aluOp=0010, aluSrc=1, wrReg high exactly 1 cycle, updPC 1 cycle, 5 cycles FETCH to FETCH.
REQ-037 LD 0x11, memAck after 3 MEM cycles -> rdMem high 3 cycles, mToReg=1 and wrReg=1 in WB, then updPC.
REQ-038 ST 0x12, memAck never, MEM_TIMEOUT=8 -> wrMem high 8 cycles, memErr 1-cycle pulse, no wrReg, updPC next.
REQ-039 HALT 0x24, INT low 10 cycles then high -> halted=1 for all waiting cycles, updPC 1 cycle after INT sampled.
REQ-040 Opcode 0x3F -> illegal pulse in DECODE, no wrReg/rdMem/wrMem, updPC next cycle.
REQ-041 rst asserted during LD MEM wait -> next cycle all outputs 0, state FETCH; CMOV with CMOV_SETTLE=2 -> wrReg exactly 2 cycles after EXEC end, isCmov=1 throughout.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle instruction sequencer for a simple datapath.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (CSETTLE | MEM) ->
// WB -> UPD, with a HALT state that waits for INT. Every output is a register:
// the output block decodes the *next* state and the value lands on the same
// edge as the state change, so each cycle's outputs belong to the state the
// FSM occupies during that cycle.
//
// Parameters
//   ALU_LAT      cycles spent in EXEC (1..15)
//   MEM_TIMEOUT  MEM cycles without memAck before abort (1..255)
//   CMOV_SETTLE  extra flag-settle cycles for CMOV after EXEC (0..7)
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   opcode[5:0], func[4:0] instruction fields, captured on entry to DECODE
//   INT                    resume request, honoured only in HALT
//   memAck                 memory completion, honoured only in MEM
//   aluOp[3:0], brOp[2:0]  ALU op / branch condition (100 = none)
//   aluSrc, regAluOut, immSel, isCmov, mToReg   datapath selects
//   rdMem, wrMem, wrReg, updPC                  strobes
//   halted, illegal, memErr                     status
module multicycle_ctrl #(
  parameter int ALU_LAT     = 1,
  parameter int MEM_TIMEOUT = 8,
  parameter int CMOV_SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [4:0] func,
  input  logic       INT,
  input  logic       memAck,
  output logic [3:0] aluOp,
  output logic [2:0] brOp,
  output logic       aluSrc,
  output logic       regAluOut,
  output logic       immSel,
  output logic       isCmov,
  output logic       mToReg,
  output logic       rdMem,
  output logic       wrMem,
  output logic       wrReg,
  output logic       updPC,
  output logic       halted,
  output logic       illegal,
  output logic       memErr
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_CSETTLE, S_MEM, S_WB, S_UPD, S_HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LUI  = 6'h10;
  localparam logic [5:0] OP_LD   = 6'h11;
  localparam logic [5:0] OP_ST   = 6'h12;
  localparam logic [5:0] OP_MOVE = 6'h14;
  localparam logic [5:0] OP_CMOV = 6'h15;
  localparam logic [5:0] OP_BR   = 6'h20;
  localparam logic [5:0] OP_BZ   = 6'h23;
  localparam logic [5:0] OP_HALT = 6'h24;
  localparam logic [5:0] OP_NOP  = 6'h25;
  localparam logic [5:0] OP_LAST = 6'h26;

  // Counter value on the final cycle of each timed state. CSET_LAST is
  // meaningless when CMOV_SETTLE is 0 because CSETTLE is then never entered.
  localparam logic [7:0] EXEC_LAST = 8'(ALU_LAT - 1);
  localparam logic [7:0] CSET_LAST = 8'(CMOV_SETTLE - 1);
  localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] MEM_ERR   = 8'(MEM_TIMEOUT);

  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic [5:0] r_opc;
  logic [3:0] r_func;

  // Only func[3:0] selects an ALU operation.
  logic w_unused;
  assign w_unused = func[4];

  // While leaving FETCH the instruction is taken straight from the inputs so
  // that DECODE-cycle outputs already reflect it; afterwards the latched copy.
  logic [5:0] w_opc;
  logic [3:0] w_func;
  assign w_opc  = (r_state == S_FETCH) ? opcode      : r_opc;
  assign w_func = (r_state == S_FETCH) ? func[3:0]   : r_func;

  logic       w_legal, w_is_br, w_is_ld, w_is_st, w_is_cmov, w_is_nop, w_is_halt;
  logic       w_alusrc;
  logic [3:0] w_aluop;
  logic [2:0] w_brop;

  always_comb begin
    w_is_br   = (w_opc >= OP_BR) && (w_opc <= OP_BZ);
    w_is_ld   = (w_opc == OP_LD);
    w_is_st   = (w_opc == OP_ST);
    w_is_cmov = (w_opc == OP_CMOV);
    w_is_nop  = (w_opc == OP_NOP);
    w_is_halt = (w_opc == OP_HALT);
    w_legal   = (w_opc <= OP_ST) || (w_opc == OP_MOVE) || w_is_cmov ||
                ((w_opc >= OP_BR) && (w_opc <= OP_LAST));
    w_alusrc  = (w_opc == OP_R) || (w_opc == OP_MOVE) || w_is_cmov;
    w_brop    = w_is_br ? {1'b0, w_opc[1:0]} : 3'b100;
    if (w_opc == OP_R)        w_aluop = w_func - 4'd1;
    else if (w_opc < OP_LUI)  w_aluop = w_opc[3:0] - 4'd1;
    else if (w_opc == OP_LUI) w_aluop = 4'hF;
    else                      w_aluop = 4'h0;
  end

  // Last counted MEM cycle passed without an ack: spend one extra MEM cycle
  // with strobes dropped and memErr raised, then abort to UPD.
  logic w_tmo;
  assign w_tmo = (r_state == S_MEM) && (r_cnt == MEM_LAST) && !memAck;

  // State register, cycle counter and instruction latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= 8'd0;
      r_opc   <= 6'd0;
      r_func  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
      if (r_state == S_FETCH) begin
        r_opc  <= opcode;
        r_func <= func[3:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal)       w_next = S_UPD;
        else if (w_is_halt) w_next = S_HALT;
        else                w_next = S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt == EXEC_LAST) begin
          if (w_is_ld || w_is_st)      w_next = S_MEM;
          else if (w_is_cmov)          w_next = (CMOV_SETTLE == 0) ? S_WB : S_CSETTLE;
          else if (w_is_br || w_is_nop) w_next = S_UPD;
          else                         w_next = S_WB;
        end
      end
      S_CSETTLE: if (r_cnt == CSET_LAST) w_next = S_WB;
      S_MEM: begin
        if (r_cnt == MEM_ERR) w_next = S_UPD;
        else if (memAck)      w_next = w_is_ld ? S_WB : S_UPD;
      end
      S_WB:     w_next = S_UPD;
      S_UPD:    w_next = S_FETCH;
      S_HALT:   if (INT) w_next = S_UPD;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode of the upcoming state.
  logic [3:0] w_aluOp_n;
  logic [2:0] w_brOp_n;
  logic       w_aluSrc_n, w_immSel_n, w_isCmov_n, w_mToReg_n;
  logic       w_rdMem_n, w_wrMem_n, w_wrReg_n, w_updPC_n;
  logic       w_halted_n, w_illegal_n, w_memErr_n;

  always_comb begin
    w_aluOp_n   = 4'h0;
    w_brOp_n    = 3'b100;
    w_aluSrc_n  = 1'b0;
    w_immSel_n  = 1'b0;
    w_isCmov_n  = 1'b0;
    w_mToReg_n  = 1'b0;
    w_rdMem_n   = 1'b0;
    w_wrMem_n   = 1'b0;
    w_wrReg_n   = 1'b0;
    w_updPC_n   = 1'b0;
    w_halted_n  = 1'b0;
    w_illegal_n = 1'b0;
    w_memErr_n  = 1'b0;
    // Selects stay valid for the whole instruction; FETCH shows the idle values.
    if (w_next != S_FETCH) begin
      w_aluOp_n  = w_aluop;
      w_brOp_n   = w_brop;
      w_aluSrc_n = w_alusrc;
      w_immSel_n = w_is_br;
    end
    w_isCmov_n  = w_is_cmov && (w_next inside {S_DECODE, S_EXEC, S_CSETTLE, S_WB});
    w_mToReg_n  = w_is_ld && (w_next == S_WB);
    w_rdMem_n   = w_is_ld && (w_next == S_MEM) && !w_tmo;
    w_wrMem_n   = w_is_st && (w_next == S_MEM) && !w_tmo;
    w_memErr_n  = w_tmo;
    w_wrReg_n   = (w_next == S_WB);
    w_updPC_n   = (w_next == S_UPD);
    w_halted_n  = (w_next == S_HALT);
    w_illegal_n = (w_next == S_DECODE) && !w_legal;
  end

  logic [3:0] r_aluOp;
  logic [2:0] r_brOp;
  logic       r_aluSrc, r_immSel, r_isCmov, r_mToReg;
  logic       r_rdMem, r_wrMem, r_wrReg, r_updPC, r_halted, r_illegal, r_memErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluOp   <= 4'h0;
      r_brOp    <= 3'b100;
      r_aluSrc  <= 1'b0;
      r_immSel  <= 1'b0;
      r_isCmov  <= 1'b0;
      r_mToReg  <= 1'b0;
      r_rdMem   <= 1'b0;
      r_wrMem   <= 1'b0;
      r_wrReg   <= 1'b0;
      r_updPC   <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_memErr  <= 1'b0;
    end else begin
      r_aluOp   <= w_aluOp_n;
      r_brOp    <= w_brOp_n;
      r_aluSrc  <= w_aluSrc_n;
      r_immSel  <= w_immSel_n;
      r_isCmov  <= w_isCmov_n;
      r_mToReg  <= w_mToReg_n;
      r_rdMem   <= w_rdMem_n;
      r_wrMem   <= w_wrMem_n;
      r_wrReg   <= w_wrReg_n;
      r_updPC   <= w_updPC_n;
      r_halted  <= w_halted_n;
      r_illegal <= w_illegal_n;
      r_memErr  <= w_memErr_n;
    end
  end

  // aluSrc and regAluOut are asserted by the same instruction set.
  assign aluOp     = r_aluOp;
  assign brOp      = r_brOp;
  assign aluSrc    = r_aluSrc;
  assign regAluOut = r_aluSrc;
  assign immSel    = r_immSel;
  assign isCmov    = r_isCmov;
  assign mToReg    = r_mToReg;
  assign rdMem     = r_rdMem;
  assign wrMem     = r_wrMem;
  assign wrReg     = r_wrReg;
  assign updPC     = r_updPC;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign memErr    = r_memErr;

endmodule
